// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush controller for the 5-stage core.
// Detects load-use hazards, freezes the pipeline while the memory stage waits
// on an AXI data transaction, sequences redirect flushes and traps memory
// transactions that never complete. Writeback is never stalled.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> saturating performance counters are built
//   undefined -> perf ports are tied to zero, no counter flops exist
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT    = 256,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] decode_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] decode_rs2,
    input  logic                      decode_uses_rs1,
    input  logic                      decode_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] execute_rd,
    input  logic                      execute_is_load,
    input  logic                      execute_regfile_wr_enable,
    input  logic                      execute_pc_src,
    input  logic                      mem_req,
    input  logic                      mem_done,
    output logic                      stall_fetch,
    output logic                      stall_decode,
    output logic                      stall_execute,
    output logic                      stall_mem,
    output logic                      flush_decode,
    output logic                      flush_execute,
    output logic                      mem_timeout_err,
    output logic [1:0]                state,
    output logic [CNT_WIDTH-1:0]      perf_load_use_cnt,
    output logic [CNT_WIDTH-1:0]      perf_mem_wait_cnt,
    output logic [CNT_WIDTH-1:0]      perf_flush_cnt
);

    // Encoding 2'd2 is never entered; the default case arm treats it as RUN.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd3
    } state_t;

    localparam int WAIT_WIDTH = $clog2(MEM_TIMEOUT + 1);

    state_t                state_q, state_d;
    logic [WAIT_WIDTH-1:0] wait_q, wait_d;
    logic                  lu;        // load-use hazard between execute and decode
    logic                  mb;        // memory stage busy this cycle
    logic                  hold_all;  // freeze fetch..memory
    logic                  run_eval;  // apply redirect / load-use rules this cycle

    assign lu = execute_is_load & execute_regfile_wr_enable & (execute_rd != '0) &
                ((decode_uses_rs1 & (decode_rs1 == execute_rd)) |
                 (decode_uses_rs2 & (decode_rs2 == execute_rd)));

    assign mb = mem_req & ~mem_done;

    // Next-state logic: decides freeze vs. normal evaluation and the wait counter.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no
        // path can leave it unassigned and infer a latch.
        state_d  = state_q;
        wait_d   = wait_q;
        hold_all = 1'b0;
        run_eval = 1'b0;
        case (state_q)
            ST_MEM_WAIT: begin
                if (mem_done) begin
                    // Release cycle: stalls drop and the RUN rules apply now.
                    state_d  = ST_RUN;
                    run_eval = 1'b1;
                end else begin
                    hold_all = 1'b1;
                    if (wait_q == WAIT_WIDTH'(MEM_TIMEOUT)) begin
                        state_d = ST_ERROR;
                    end else begin
                        wait_d = wait_q + WAIT_WIDTH'(1);
                    end
                end
            end
            ST_ERROR: begin
                hold_all = 1'b1;
            end
            default: begin
                if (mb) begin
                    hold_all = 1'b1;
                    state_d  = ST_MEM_WAIT;
                    wait_d   = WAIT_WIDTH'(1);
                end else begin
                    run_eval = 1'b1;
                end
            end
        endcase
    end

    // Stall/flush outputs: reset forces bubbles, freeze beats redirect beats load-use.
    always_comb begin
        stall_fetch   = 1'b0;
        stall_decode  = 1'b0;
        stall_execute = 1'b0;
        stall_mem     = 1'b0;
        flush_decode  = 1'b0;
        flush_execute = 1'b0;
        if (rst) begin
            flush_decode  = 1'b1;
            flush_execute = 1'b1;
        end else if (hold_all) begin
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            stall_execute = 1'b1;
            stall_mem     = 1'b1;
        end else if (run_eval) begin
            if (execute_pc_src) begin
                // The decode instruction is wrong-path, so its hazard is moot.
                flush_decode  = 1'b1;
                flush_execute = 1'b1;
            end else if (lu) begin
                stall_fetch   = 1'b1;
                stall_decode  = 1'b1;
                flush_execute = 1'b1;
            end
        end
    end

    assign mem_timeout_err = ~rst & (state_q == ST_ERROR);
    assign state           = rst ? 2'b00 : state_q;

    // State register and wait counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic lu_event;
    logic wait_event;
    logic redirect_event;

    assign lu_event       = ~rst & run_eval & ~execute_pc_src & lu;
    assign wait_event     = ~rst & hold_all & (state_q == ST_MEM_WAIT);
    assign redirect_event = ~rst & run_eval & execute_pc_src;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_load_use_cnt <= '0;
            perf_mem_wait_cnt <= '0;
            perf_flush_cnt    <= '0;
        end else begin
            if (lu_event && (perf_load_use_cnt != '1)) begin
                perf_load_use_cnt <= perf_load_use_cnt + CNT_WIDTH'(1);
            end
            if (wait_event && (perf_mem_wait_cnt != '1)) begin
                perf_mem_wait_cnt <= perf_mem_wait_cnt + CNT_WIDTH'(1);
            end
            if (redirect_event && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + CNT_WIDTH'(1);
            end
        end
    end
`else
    assign perf_load_use_cnt = '0;
    assign perf_mem_wait_cnt = '0;
    assign perf_flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=8, CNT_WIDTH=4).
// A cycle-level behavioural model is compared against the DUT on every falling
// edge; directed steps add literal expectations that pin the model.
module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;
    localparam int TO = 8;
    localparam int CW = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] decode_rs1, decode_rs2, execute_rd;
    logic          decode_uses_rs1, decode_uses_rs2;
    logic          execute_is_load, execute_regfile_wr_enable, execute_pc_src;
    logic          mem_req, mem_done;
    logic          stall_fetch, stall_decode, stall_execute, stall_mem;
    logic          flush_decode, flush_execute, mem_timeout_err;
    logic [1:0]    state;
    logic [CW-1:0] perf_load_use_cnt, perf_mem_wait_cnt, perf_flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_hazard_ctrl #(
        .REG_ADDR_WIDTH(AW),
        .MEM_TIMEOUT   (TO),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .decode_rs1               (decode_rs1),
        .decode_rs2               (decode_rs2),
        .decode_uses_rs1          (decode_uses_rs1),
        .decode_uses_rs2          (decode_uses_rs2),
        .execute_rd               (execute_rd),
        .execute_is_load          (execute_is_load),
        .execute_regfile_wr_enable(execute_regfile_wr_enable),
        .execute_pc_src           (execute_pc_src),
        .mem_req                  (mem_req),
        .mem_done                 (mem_done),
        .stall_fetch              (stall_fetch),
        .stall_decode             (stall_decode),
        .stall_execute            (stall_execute),
        .stall_mem                (stall_mem),
        .flush_decode             (flush_decode),
        .flush_execute            (flush_execute),
        .mem_timeout_err          (mem_timeout_err),
        .state                    (state),
        .perf_load_use_cnt        (perf_load_use_cnt),
        .perf_mem_wait_cnt        (perf_mem_wait_cnt),
        .perf_flush_cnt           (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_waiting   = 1'b0;  // a memory transaction is being waited on
    bit m_error     = 1'b0;  // timeout trapped
    int m_wait_n    = 0;     // stalled wait cycles of the current transaction
    int m_lu_n      = 0;
    int m_memwait_n = 0;
    int m_flush_n   = 0;

    function automatic bit reads_loaded_reg();
        if (!(execute_is_load && execute_regfile_wr_enable) || execute_rd == 0) return 1'b0;
        return (decode_uses_rs1 && decode_rs1 == execute_rd) ||
               (decode_uses_rs2 && decode_rs2 == execute_rd);
    endfunction

    function automatic logic [31:0] sat(input int n);
        return PERF_ON ? ((n > 15) ? 32'd15 : 32'(n)) : 32'd0;
    endfunction

    // Compare process: expected outputs from the model, then advance the model.
    always @(negedge clk) begin : compare
        bit freeze, e_sf, e_sd, e_fd, e_fe, e_err;
        logic [1:0] e_st;
        freeze = 1'b0; e_sf = 1'b0; e_sd = 1'b0; e_fd = 1'b0; e_fe = 1'b0;
        e_err = 1'b0; e_st = 2'd0;
        if (rst) begin
            e_fd = 1'b1; e_fe = 1'b1;
        end else if (m_error) begin
            freeze = 1'b1; e_err = 1'b1; e_st = 2'd3;
        end else begin
            e_st = m_waiting ? 2'd1 : 2'd0;
            freeze = m_waiting ? !mem_done : (mem_req && !mem_done);
            if (!freeze) begin
                if (execute_pc_src) begin
                    e_fd = 1'b1; e_fe = 1'b1;
                end else if (reads_loaded_reg()) begin
                    e_sf = 1'b1; e_sd = 1'b1; e_fe = 1'b1;
                end
            end
        end
        if (freeze) begin
            e_sf = 1'b1; e_sd = 1'b1;
        end
        check("ctl",
              {23'd0, stall_fetch, stall_decode, stall_execute, stall_mem,
               flush_decode, flush_execute, mem_timeout_err, state},
              {23'd0, e_sf, e_sd, freeze, freeze, e_fd, e_fe, e_err, e_st});
        check("perf_lu",    32'(perf_load_use_cnt), sat(m_lu_n));
        check("perf_wait",  32'(perf_mem_wait_cnt), sat(m_memwait_n));
        check("perf_flush", 32'(perf_flush_cnt),    sat(m_flush_n));

        if (rst) begin
            m_waiting = 1'b0; m_error = 1'b0; m_wait_n = 0;
            m_lu_n = 0; m_memwait_n = 0; m_flush_n = 0;
        end else if (!m_error) begin
            if (e_fd) m_flush_n++;
            if (e_sf && !freeze) m_lu_n++;
            if (m_waiting) begin
                if (mem_done) begin
                    m_waiting = 1'b0;
                end else begin
                    m_wait_n++;
                    m_memwait_n++;
                    if (m_wait_n == TO) begin
                        m_error = 1'b1;
                        m_waiting = 1'b0;
                    end
                end
            end else if (mem_req && !mem_done) begin
                m_waiting = 1'b1;
                m_wait_n = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_in();
        decode_rs1 = '0; decode_rs2 = '0; execute_rd = '0;
        decode_uses_rs1 = 1'b0; decode_uses_rs2 = 1'b0;
        execute_is_load = 1'b0; execute_regfile_wr_enable = 1'b0;
        execute_pc_src = 1'b0; mem_req = 1'b0; mem_done = 1'b0;
    endtask

    // Load into x<rd> in execute, decode reads x<rs2> via rs2.
    task automatic load_use(input logic [AW-1:0] rd, input logic [AW-1:0] rs2);
        execute_is_load = 1'b1; execute_regfile_wr_enable = 1'b1; execute_rd = rd;
        decode_rs1 = 5'd3; decode_uses_rs1 = 1'b1;
        decode_rs2 = rs2;  decode_uses_rs2 = 1'b1;
    endtask

    task automatic clear_execute();
        execute_is_load = 1'b0; execute_regfile_wr_enable = 1'b0; execute_rd = '0;
    endtask

    initial begin
        idle_in();
        rst = 1'b1; mem_req = 1'b1; execute_pc_src = 1'b1;
        tick();
        check("rst_outs", {stall_fetch, stall_mem, flush_decode, flush_execute, state},
              6'b001100);
        tick(2);

        // Idle after reset: everything quiet.
        rst = 1'b0; idle_in(); #1;
        check("idle_outs", {stall_fetch, stall_decode, stall_execute, stall_mem,
                            flush_decode, flush_execute, mem_timeout_err, state}, 9'd0);
        tick();

        // Load-use on x5: one bubble, then the execute slot is a bubble.
        load_use(5'd5, 5'd5); #1;
        check("lu_pattern", {stall_fetch, stall_decode, stall_execute, stall_mem,
                             flush_decode, flush_execute}, 6'b110001);
        tick();
        clear_execute(); #1;
        check("lu_one_cycle", stall_fetch, 1'b0);
        tick();
        load_use(5'd0, 5'd0); #1;
        check("lu_x0", stall_fetch, 1'b0);
        tick();
        idle_in(); tick();

        // Memory wait: RUN detection cycle, 4 stalled waits, release.
        mem_req = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin
            check("wait_state", {state, stall_execute}, 3'b011);
            tick();
        end
        mem_done = 1'b1; #1;
        check("release", {stall_fetch, stall_mem, state}, 4'b0001);
        tick();
        idle_in(); #1;
        check("back_run", state, 2'd0);
        check("perf_wait_4", perf_mem_wait_cnt, PERF_ON ? 4'd4 : 4'd0);
        tick();

        // Redirect beats load-use in RUN.
        load_use(5'd7, 5'd7); execute_pc_src = 1'b1; #1;
        check("pc_vs_lu", {flush_decode, flush_execute, stall_fetch}, 3'b110);
        tick();
        idle_in(); tick();

        // Redirect held during a memory wait flushes only on release.
        mem_req = 1'b1; execute_pc_src = 1'b1; #1;
        check("pc_mb_run", flush_decode, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            check("pc_held", {flush_decode, stall_execute}, 2'b01);
            tick();
        end
        mem_done = 1'b1; #1;
        check("pc_release", {flush_decode, flush_execute, stall_execute}, 3'b110);
        tick();
        idle_in(); tick();
        check("perf_flush_2", perf_flush_cnt, PERF_ON ? 4'd2 : 4'd0);

        // Timeout: 8 stalled waits then ERROR until reset.
        mem_req = 1'b1; tick();
        tick(7);
        check("wait8_state", state, 2'd1);
        tick();
        check("err_enter", {mem_timeout_err, state}, 3'b111);
        mem_req = 1'b0; mem_done = 1'b1;
        tick(3);
        check("err_sticky", {mem_timeout_err, state, stall_fetch, flush_decode}, 5'b11110);
        rst = 1'b1; #1;
        check("err_rst", {mem_timeout_err, state}, 3'b000);
        tick();
        rst = 1'b0; idle_in(); tick();

        // Completion on the 8th wait cycle wins over the timeout.
        mem_req = 1'b1; tick();
        tick(7);
        mem_done = 1'b1; tick();
        idle_in(); #1;
        check("done_at_to", {mem_timeout_err, state}, 3'b000);
        tick();

        // Counter saturation: 20 load-use events on a 4-bit counter.
        rst = 1'b1; tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            load_use(5'd9, 5'd9); tick();
            clear_execute(); tick();
        end
        check("lu_sat", perf_load_use_cnt, PERF_ON ? 4'd15 : 4'd0);
        idle_in(); tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
